// File: rtl/display_scan_mux.sv
// Four-digit common-anode 7-segment scanner driven by an external refresh square wave.
// Each digit change inserts an all-anodes-off guard, and digits come from a per-frame snapshot.
module display_scan_mux #(
   parameter int unsigned GUARD_CYCLES     = 8,
   parameter bit          ANODE_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic        refresh_in,
   input  logic [15:0] value_in,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start
);

   localparam int unsigned DIGITS = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned SEG_W  = 7;
   localparam int unsigned CNT_W  = 8;

   localparam logic [DIGITS-1:0] AN_OFF     = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [SEG_W-1:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic              DP_OFF     = SEG_ACTIVE_LOW;
   localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(GUARD_CYCLES);
   localparam logic              NO_GUARD   = (GUARD_CYCLES == 0);

   localparam logic [0:0] ST_GUARD = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   // Active-high gfedcba patterns for one hex nibble
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] h);
      logic [SEG_W-1:0] p;
      p = 7'h00;
      case (h)
         4'h0: p = 7'h3F;
         4'h1: p = 7'h06;
         4'h2: p = 7'h5B;
         4'h3: p = 7'h4F;
         4'h4: p = 7'h66;
         4'h5: p = 7'h6D;
         4'h6: p = 7'h7D;
         4'h7: p = 7'h07;
         4'h8: p = 7'h7F;
         4'h9: p = 7'h6F;
         4'hA: p = 7'h77;
         4'hB: p = 7'h7C;
         4'hC: p = 7'h39;
         4'hD: p = 7'h5E;
         4'hE: p = 7'h79;
         4'hF: p = 7'h71;
      endcase
      return p;
   endfunction

   function automatic logic [DIGITS-1:0] anode_on(input logic [IDX_W-1:0] i);
      return (4'b0001 << i) ^ AN_OFF;
   endfunction

   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              prev_q, prev_d;
   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  guard_cnt_q, guard_cnt_d;
   logic [15:0]       val_q, val_d;
   logic [3:0]        dps_q, dps_d;
   logic              blz_q, blz_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]  seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              fs_q, fs_d;

   logic              step_c;
   logic              wrap_c;
   logic [IDX_W-1:0]  idx_nxt_c;
   logic [15:0]       val_sel_c;
   logic [3:0]        dp_sel_c;
   logic              blz_sel_c;
   logic [3:0]        nib_c;
   logic [3:0]        nib_zero_c;
   logic [3:0]        hi_zero_c;
   logic              blank_c;
   logic [SEG_W-1:0]  seg_new_c;
   logic              dp_new_c;

   // Pattern for the digit about to be selected, using the snapshot that will be live then
   always_comb begin
      step_c    = sync2_q & ~prev_q;
      wrap_c    = step_c && (idx_q == 2'd3);
      idx_nxt_c = idx_q + 2'd1;
      val_sel_c = wrap_c ? value_in : val_q;
      dp_sel_c  = wrap_c ? dp_in    : dps_q;
      blz_sel_c = wrap_c ? blank_lz : blz_q;
      nib_c     = val_sel_c[{idx_nxt_c, 2'b00} +: 4];
      nib_zero_c = 4'h0;
      for (int i = 0; i < 4; i++) begin
         nib_zero_c[i] = (val_sel_c[i*4 +: 4] == 4'h0);
      end
      hi_zero_c[3] = nib_zero_c[3];
      hi_zero_c[2] = nib_zero_c[2] & hi_zero_c[3];
      hi_zero_c[1] = nib_zero_c[1] & hi_zero_c[2];
      hi_zero_c[0] = nib_zero_c[0] & hi_zero_c[1];
      blank_c   = blz_sel_c && (idx_nxt_c != 2'd0) && hi_zero_c[idx_nxt_c];
      seg_new_c = blank_c ? 7'h00 : hex_to_seg(nib_c);
      if (SEG_ACTIVE_LOW) begin
         seg_new_c = ~seg_new_c;
      end
      dp_new_c  = SEG_ACTIVE_LOW ? ~dp_sel_c[idx_nxt_c] : dp_sel_c[idx_nxt_c];
   end

   // Next-state logic: a step always wins, otherwise the guard counts down
   always_comb begin
      sync1_d     = refresh_in;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      state_d     = state_q;
      idx_d       = idx_q;
      guard_cnt_d = guard_cnt_q;
      val_d       = val_q;
      dps_d       = dps_q;
      blz_d       = blz_q;
      an_d        = an_q;
      seg_d       = seg_q;
      dp_d        = dp_q;
      fs_d        = 1'b0;

      if (step_c) begin
         idx_d       = idx_nxt_c;
         an_d        = AN_OFF;
         seg_d       = seg_new_c;
         dp_d        = dp_new_c;
         guard_cnt_d = GUARD_LOAD;
         state_d     = ST_GUARD;
         if (wrap_c) begin
            val_d = value_in;
            dps_d = dp_in;
            blz_d = blank_lz;
            fs_d  = 1'b1;
         end
         if (NO_GUARD) begin
            state_d = ST_SHOW;
            an_d    = anode_on(idx_nxt_c);
         end
      end else begin
         case (state_q)
            ST_GUARD: begin
               if (guard_cnt_q != 8'd0) begin
                  guard_cnt_d = guard_cnt_q - 8'd1;
                  if (guard_cnt_q == 8'd1) begin
                     state_d = ST_SHOW;
                     an_d    = anode_on(idx_q);
                  end
               end
            end
            default: begin
               state_d = ST_SHOW;
            end
         endcase
      end
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         state_q     <= ST_GUARD;
         idx_q       <= 2'd3;
         guard_cnt_q <= 8'd0;
         val_q       <= 16'h0000;
         dps_q       <= 4'h0;
         blz_q       <= 1'b0;
         an_q        <= AN_OFF;
         seg_q       <= SEG_OFF;
         dp_q        <= DP_OFF;
         fs_q        <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         guard_cnt_q <= guard_cnt_d;
         val_q       <= val_d;
         dps_q       <= dps_d;
         blz_q       <= blz_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         fs_q        <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: an 8-cycle-guard instance and a zero-guard instance
// share stimulus; expected segment codes are hand-computed active-low constants.
module tb_display_scan_mux;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        refresh_in = 1'b0;
   logic [15:0] value_in = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an, an0;
   logic [6:0]  seg, seg0;
   logic        dp, dp0;
   logic        fs, fs0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   display_scan_mux #(.GUARD_CYCLES(8), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clock_in(clk), .reset(reset), .refresh_in(refresh_in), .value_in(value_in),
      .dp_in(dp_in), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_start(fs));

   display_scan_mux #(.GUARD_CYCLES(0), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut0 (
      .clock_in(clk), .reset(reset), .refresh_in(refresh_in), .value_in(value_in),
      .dp_in(dp_in), .blank_lz(blank_lz), .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0));

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dpi;
      logic        blz;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic        fs;
   } vec_t;

   vec_t vecs[28];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, " an"}, 16'(an), 16'hF);
      check({name, " seg"}, 16'(seg), 16'h7F);
      check({name, " dp"}, 16'(dp), 16'h1);
      check({name, " fs"}, 16'(fs), 16'h0);
      check({name, " an0"}, 16'(an0), 16'hF);
   endtask

   // One refresh pulse: step lands on the 3rd edge, anode appears 8 edges later
   task automatic do_step(input vec_t v, input string name);
      value_in   = v.val;
      dp_in      = v.dpi;
      blank_lz   = v.blz;
      refresh_in = 1'b1;
      tick(); tick(); tick();
      check({name, " step an"}, 16'(an), 16'hF);
      check({name, " step seg"}, 16'(seg), 16'(v.seg));
      check({name, " step dp"}, 16'(dp), 16'(v.dp));
      check({name, " step fs"}, 16'(fs), 16'(v.fs));
      check({name, " g0 an0"}, 16'(an0), 16'(v.an));
      check({name, " g0 seg0"}, 16'(seg0), 16'(v.seg));
      for (int k = 1; k <= 7; k++) begin
         tick();
         check({name, " guard an"}, 16'(an), 16'hF);
         if (k == 1) check({name, " fs drop"}, 16'(fs), 16'h0);
      end
      tick();
      check({name, " show an"}, 16'(an), 16'(v.an));
      check({name, " show seg"}, 16'(seg), 16'(v.seg));
      refresh_in = 1'b0;
      tick(); tick(); tick();
      check({name, " hold an"}, 16'(an), 16'(v.an));
      check({name, " hold dp"}, 16'(dp), 16'(v.dp));
   endtask

   initial begin
      vec_t v;
      // 1234, no blanking
      vecs[0]  = '{16'h1234, 4'h0, 1'b0, 4'hE, 7'h19, 1'b1, 1'b1};
      vecs[1]  = '{16'h1234, 4'h0, 1'b0, 4'hD, 7'h30, 1'b1, 1'b0};
      vecs[2]  = '{16'h1234, 4'h0, 1'b0, 4'hB, 7'h24, 1'b1, 1'b0};
      vecs[3]  = '{16'h1234, 4'h0, 1'b0, 4'h7, 7'h79, 1'b1, 1'b0};
      // 0050 with blanking, dp on digit2
      vecs[4]  = '{16'h0050, 4'h4, 1'b1, 4'hE, 7'h40, 1'b1, 1'b1};
      vecs[5]  = '{16'h0050, 4'h4, 1'b1, 4'hD, 7'h12, 1'b1, 1'b0};
      vecs[6]  = '{16'h0050, 4'h4, 1'b1, 4'hB, 7'h7F, 1'b0, 1'b0};
      vecs[7]  = '{16'h0050, 4'h4, 1'b1, 4'h7, 7'h7F, 1'b1, 1'b0};
      // 1111 changed to 2222 mid-frame: no tearing
      vecs[8]  = '{16'h1111, 4'h0, 1'b0, 4'hE, 7'h79, 1'b1, 1'b1};
      vecs[9]  = '{16'h1111, 4'h0, 1'b0, 4'hD, 7'h79, 1'b1, 1'b0};
      vecs[10] = '{16'h2222, 4'h0, 1'b0, 4'hB, 7'h79, 1'b1, 1'b0};
      vecs[11] = '{16'h2222, 4'h0, 1'b0, 4'h7, 7'h79, 1'b1, 1'b0};
      vecs[12] = '{16'h2222, 4'h0, 1'b0, 4'hE, 7'h24, 1'b1, 1'b1};
      vecs[13] = '{16'h2222, 4'h0, 1'b0, 4'hD, 7'h24, 1'b1, 1'b0};
      vecs[14] = '{16'h2222, 4'h0, 1'b0, 4'hB, 7'h24, 1'b1, 1'b0};
      vecs[15] = '{16'h2222, 4'h0, 1'b0, 4'h7, 7'h24, 1'b1, 1'b0};
      // E0F0: inner zero not blanked because a higher digit is nonzero
      vecs[16] = '{16'hE0F0, 4'h9, 1'b1, 4'hE, 7'h40, 1'b0, 1'b1};
      vecs[17] = '{16'hE0F0, 4'h9, 1'b1, 4'hD, 7'h0E, 1'b1, 1'b0};
      vecs[18] = '{16'hE0F0, 4'h9, 1'b1, 4'hB, 7'h40, 1'b1, 1'b0};
      vecs[19] = '{16'hE0F0, 4'h9, 1'b1, 4'h7, 7'h06, 1'b0, 1'b0};
      // ABCD letters
      vecs[20] = '{16'hABCD, 4'h0, 1'b0, 4'hE, 7'h21, 1'b1, 1'b1};
      vecs[21] = '{16'hABCD, 4'h0, 1'b0, 4'hD, 7'h46, 1'b1, 1'b0};
      vecs[22] = '{16'hABCD, 4'h0, 1'b0, 4'hB, 7'h03, 1'b1, 1'b0};
      vecs[23] = '{16'hABCD, 4'h0, 1'b0, 4'h7, 7'h08, 1'b1, 1'b0};
      // All zero with blanking: digit0 still shows '0'
      vecs[24] = '{16'h0000, 4'h0, 1'b1, 4'hE, 7'h40, 1'b1, 1'b1};
      vecs[25] = '{16'h0000, 4'h0, 1'b1, 4'hD, 7'h7F, 1'b1, 1'b0};
      vecs[26] = '{16'h0000, 4'h0, 1'b1, 4'hB, 7'h7F, 1'b1, 1'b0};
      vecs[27] = '{16'h0000, 4'h0, 1'b1, 4'h7, 7'h7F, 1'b1, 1'b0};

      // Reset held while refresh toggles
      tick();
      for (int i = 0; i < 6; i++) begin
         refresh_in = ~refresh_in;
         tick();
         check_idle("rst held");
      end
      refresh_in = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("post-rst an", 16'(an), 16'hF);
      end

      for (int i = 0; i < 28; i++) begin
         do_step(vecs[i], $sformatf("vec%0d", i));
      end

      // Zero guard: refresh edges three clocks apart
      value_in = 16'h4321;
      dp_in    = 4'h0;
      blank_lz = 1'b0;
      refresh_in = 1'b1; tick(); tick(); refresh_in = 1'b0; tick();
      check("g0 s1 an0", 16'(an0), 16'hE);
      check("g0 s1 seg0", 16'(seg0), 16'h79);
      check("g0 s1 fs", 16'(fs), 16'h1);
      check("g0 s1 an", 16'(an), 16'hF);
      refresh_in = 1'b1; tick();
      check("g0 hold an0", 16'(an0), 16'hE);
      tick(); refresh_in = 1'b0; tick();
      check("g0 s2 an0", 16'(an0), 16'hD);
      check("g0 s2 seg0", 16'(seg0), 16'h24);
      check("g0 s2 an", 16'(an), 16'hF);
      refresh_in = 1'b1; tick(); tick(); refresh_in = 1'b0; tick();
      check("g0 s3 an0", 16'(an0), 16'hB);
      check("g0 s3 seg0", 16'(seg0), 16'h30);
      check("g0 s3 an", 16'(an), 16'hF);
      for (int k = 0; k < 8; k++) tick();
      check("restart show an", 16'(an), 16'hB);
      check("restart show seg", 16'(seg), 16'h30);

      // Reset mid-GUARD
      refresh_in = 1'b1;
      tick(); tick(); tick();
      check("pre-rst guard an", 16'(an), 16'hF);
      check("pre-rst guard seg", 16'(seg), 16'h19);
      tick(); tick(); tick();
      #2 reset = 1'b1;
      #1 check_idle("rst guard");
      refresh_in = 1'b0;
      #1 reset = 1'b0;
      tick();
      v = '{16'h0007, 4'h1, 1'b0, 4'hE, 7'h78, 1'b0, 1'b1};
      do_step(v, "after rst guard");

      // Reset mid-SHOW
      #2 reset = 1'b1;
      #1 check_idle("rst show");
      #1 reset = 1'b0;
      tick();
      do_step(v, "after rst show");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
